// File: rtl/beat_sequencer.sv
// Game-flow controller for the arrow game: master FSM, level-scaled metronome,
// and lives/level/tempo bookkeeping driven by collision events.
`timescale 1ns/1ps
module beat_sequencer #(
    parameter int CNT_BITS        = 27,
    parameter int BEAT_INIT       = 100000000,
    parameter int BEAT_STEP       = 6250000,
    parameter int BEAT_MIN        = 25000000,
    parameter int LIVES_INIT      = 3,
    parameter int HITS_PER_LEVEL  = 16,
    parameter int COUNTDOWN_BEATS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause_sw,
    input  logic       correct_hit,
    input  logic       incorrect_hit,
    input  logic       miss,
    output logic [2:0] game_state,
    output logic       beat_tick,
    output logic [2:0] lives,
    output logic [3:0] level,
    output logic [1:0] countdown,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_OVER      = 3'd4
    } state_t;

    localparam int HIT_BITS = $clog2(HITS_PER_LEVEL + 1);
    localparam logic [HIT_BITS-1:0] HIT_LAST   = HIT_BITS'(HITS_PER_LEVEL - 1);
    localparam logic [CNT_BITS-1:0] P_INIT     = CNT_BITS'(BEAT_INIT);
    localparam logic [CNT_BITS-1:0] P_STEP     = CNT_BITS'(BEAT_STEP);
    localparam logic [CNT_BITS-1:0] P_MIN      = CNT_BITS'(BEAT_MIN);
    localparam logic [CNT_BITS-1:0] P_ONE      = CNT_BITS'(1);
    localparam logic [CNT_BITS:0]   STEP_FLOOR = (CNT_BITS + 1)'(BEAT_MIN + BEAT_STEP);
    localparam logic [2:0]          L_INIT     = 3'(LIVES_INIT);
    localparam logic [1:0]          CD_INIT    = 2'(COUNTDOWN_BEATS);

    state_t                state_q, state_n;
    state_t                resume_q, resume_n;
    logic [CNT_BITS-1:0]   cnt_q, cnt_n;
    logic [CNT_BITS-1:0]   period_q, period_n;
    // target_q is the period the next wrap will load; level-ups only touch it.
    logic [CNT_BITS-1:0]   target_q, target_n;
    logic [HIT_BITS-1:0]   hit_q, hit_n;
    logic [2:0]            lives_q, lives_n;
    logic [3:0]            level_q, level_n;
    logic [1:0]            cd_q, cd_n;
    logic                  active;
    logic                  tick;
    logic                  loss;

    assign active = (state_q == S_COUNTDOWN) || (state_q == S_PLAY);
    assign tick   = active && (cnt_q == (period_q - P_ONE));
    assign loss   = incorrect_hit | miss;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            resume_q <= S_PLAY;
            cnt_q    <= '0;
            period_q <= P_INIT;
            target_q <= P_INIT;
            hit_q    <= '0;
            lives_q  <= L_INIT;
            level_q  <= 4'd0;
            cd_q     <= 2'd0;
        end else begin
            state_q  <= state_n;
            resume_q <= resume_n;
            cnt_q    <= cnt_n;
            period_q <= period_n;
            target_q <= target_n;
            hit_q    <= hit_n;
            lives_q  <= lives_n;
            level_q  <= level_n;
            cd_q     <= cd_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        resume_n = resume_q;
        cnt_n    = cnt_q;
        period_n = period_q;
        target_n = target_q;
        hit_n    = hit_q;
        lives_n  = lives_q;
        level_n  = level_q;
        cd_n     = cd_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_n  = S_COUNTDOWN;
                    lives_n  = L_INIT;
                    level_n  = 4'd0;
                    period_n = P_INIT;
                    target_n = P_INIT;
                    cnt_n    = '0;
                    hit_n    = '0;
                    cd_n     = CD_INIT;
                end
            end

            S_COUNTDOWN, S_PLAY: begin
                if (tick) begin
                    cnt_n    = '0;
                    period_n = target_q;
                end else begin
                    cnt_n = cnt_q + P_ONE;
                end

                if (state_q == S_COUNTDOWN) begin
                    if (tick) begin
                        if (cd_q == 2'd1) begin
                            state_n = S_PLAY;
                            cd_n    = 2'd0;
                        end else begin
                            cd_n = cd_q - 2'd1;
                        end
                    end
                end else if (loss) begin
                    // A simultaneous correct hit is deliberately dropped here.
                    if (lives_q <= 3'd1) begin
                        lives_n = 3'd0;
                        state_n = S_OVER;
                        cnt_n   = '0;
                    end else begin
                        lives_n = lives_q - 3'd1;
                    end
                end else if (correct_hit) begin
                    if (hit_q == HIT_LAST) begin
                        hit_n = '0;
                        if (level_q != 4'd15) level_n = level_q + 4'd1;
                        target_n = ({1'b0, target_q} < STEP_FLOOR) ? P_MIN : (target_q - P_STEP);
                    end else begin
                        hit_n = hit_q + HIT_BITS'(1);
                    end
                end

                // Resume to wherever this cycle would have gone, unless the game ended.
                if (pause_sw && (state_n != S_OVER)) begin
                    resume_n = state_n;
                    state_n  = S_PAUSE;
                end
            end

            S_PAUSE: begin
                if (!pause_sw) state_n = resume_q;
            end

            default: state_n = S_IDLE;
        endcase
    end

    assign game_state = state_q;
    assign beat_tick  = tick;
    assign lives      = lives_q;
    assign level      = level_q;
    assign countdown  = (state_q == S_COUNTDOWN) ? cd_q : 2'd0;
    assign game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: directed game scenarios plus randomized play,
// every cycle compared against a behavioural game model.
`timescale 1ns/1ps
module tb_beat_sequencer;

    localparam int B_INIT  = 10;
    localparam int B_STEP  = 2;
    localparam int B_MIN   = 4;
    localparam int L_INIT  = 3;
    localparam int HITS    = 4;
    localparam int CD_INIT = 3;

    localparam int M_IDLE = 0, M_CD = 1, M_PLAY = 2, M_PAUSE = 3, M_OVER = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause_sw = 1'b0;
    logic       correct_hit = 1'b0;
    logic       incorrect_hit = 1'b0;
    logic       miss = 1'b0;
    logic [2:0] game_state;
    logic       beat_tick;
    logic [2:0] lives;
    logic [3:0] level;
    logic [1:0] countdown;
    logic       game_over;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [13:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    beat_sequencer #(
        .CNT_BITS(27), .BEAT_INIT(B_INIT), .BEAT_STEP(B_STEP), .BEAT_MIN(B_MIN),
        .LIVES_INIT(L_INIT), .HITS_PER_LEVEL(HITS), .COUNTDOWN_BEATS(CD_INIT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause_sw(pause_sw),
        .correct_hit(correct_hit), .incorrect_hit(incorrect_hit), .miss(miss),
        .game_state(game_state), .beat_tick(beat_tick), .lives(lives),
        .level(level), .countdown(countdown), .game_over(game_over)
    );

    // ---------------- behavioural game model ----------------
    int m_mode, m_resume, m_lives, m_level, m_period, m_target, m_elapsed, m_hits, m_cd;

    task automatic model_reset();
        m_mode = M_IDLE; m_resume = M_PLAY; m_lives = L_INIT; m_level = 0;
        m_period = B_INIT; m_target = B_INIT; m_elapsed = 0; m_hits = 0; m_cd = 0;
    endtask

    function automatic bit model_tick();
        return ((m_mode == M_CD) || (m_mode == M_PLAY)) && (m_elapsed == m_period - 1);
    endfunction

    function automatic logic [13:0] model_outs();
        int cd_out;
        cd_out = (m_mode == M_CD) ? m_cd : 0;
        return {3'(m_mode), model_tick(), 3'(m_lives), 4'(m_level), 2'(cd_out), (m_mode == M_OVER)};
    endfunction

    task automatic model_step(input bit st, input bit ps, input bit ch, input bit ih, input bit ms);
        bit tick;
        int nxt;
        tick = model_tick();
        nxt  = m_mode;
        if (m_mode == M_IDLE || m_mode == M_OVER) begin
            if (st) begin
                nxt = M_CD; m_lives = L_INIT; m_level = 0; m_period = B_INIT;
                m_target = B_INIT; m_elapsed = 0; m_hits = 0; m_cd = CD_INIT;
            end
        end else if (m_mode == M_PAUSE) begin
            if (!ps) nxt = m_resume;
        end else begin
            if (tick) begin
                m_elapsed = 0;
                m_period  = m_target;
            end else begin
                m_elapsed++;
            end
            if (m_mode == M_CD) begin
                if (tick) begin
                    m_cd--;
                    if (m_cd == 0) nxt = M_PLAY;
                end
            end else if (ih || ms) begin
                m_lives--;
                if (m_lives == 0) begin
                    nxt = M_OVER;
                    m_elapsed = 0;
                end
            end else if (ch) begin
                m_hits++;
                if (m_hits == HITS) begin
                    m_hits = 0;
                    m_level = (m_level < 15) ? m_level + 1 : 15;
                    m_target = (m_target - B_STEP > B_MIN) ? m_target - B_STEP : B_MIN;
                end
            end
            if (ps && nxt != M_OVER) begin
                m_resume = nxt;
                nxt = M_PAUSE;
            end
        end
        m_mode = nxt;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        logic [13:0] e;
        if (exp_q.size() == 0) begin
            check("exp_queue_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("game_state", 32'(game_state), 32'(e[13:11]));
        check("beat_tick",  32'(beat_tick),  32'(e[10]));
        check("lives",      32'(lives),      32'(e[9:7]));
        check("level",      32'(level),      32'(e[6:3]));
        check("countdown",  32'(countdown),  32'(e[2:1]));
        check("game_over",  32'(game_over),  32'(e[0]));
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; returns at the next falling edge with outputs checked.
    task automatic cycle(input bit st, input bit ps, input bit ch, input bit ih, input bit ms);
        start = st; pause_sw = ps; correct_hit = ch; incorrect_hit = ih; miss = ms;
        model_step(st, ps, ch, ih, ms);
        exp_q.push_back(model_outs());
        @(posedge clk);
        #1;
        start = 1'b0; correct_hit = 1'b0; incorrect_hit = 1'b0; miss = 1'b0;
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input int n, input bit ps);
        for (int i = 0; i < n; i++) cycle(1'b0, ps, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_tick(output int gap);
        gap = 0;
        do begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            gap++;
        end while (!beat_tick && gap < 200);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(model_outs());
        compare_outputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        int ticks;
        bit p;

        apply_reset();
        check("rst_state", 32'(game_state), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_level", 32'(level), 32'd0);

        // Start and countdown
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("start_state", 32'(game_state), 32'd1);
        check("start_cd", 32'(countdown), 32'd3);
        next_tick(gap); check("cd_gap1", gap, 9);  check("cd_at_tick1", 32'(countdown), 32'd3);
        next_tick(gap); check("cd_gap2", gap, 10); check("cd_at_tick2", 32'(countdown), 32'd2);
        next_tick(gap); check("cd_gap3", gap, 10); check("cd_at_tick3", 32'(countdown), 32'd1);
        idle(1, 1'b0);
        check("play_state", 32'(game_state), 32'd2);
        check("play_cd", 32'(countdown), 32'd0);

        // Level-ups shorten the beat down to the floor
        for (int lv = 1; lv <= 4; lv++) begin
            for (int h = 0; h < HITS; h++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check("levelup_level", 32'(level), 32'(lv));
            next_tick(gap);
            next_tick(gap);
            check("levelup_period", gap, (lv == 1) ? 8 : (lv == 2) ? 6 : 4);
        end

        // Losses
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("double_loss_lives", 32'(lives), 32'd2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("hit_miss_lives", 32'(lives), 32'd1);
        for (int h = 0; h < HITS - 1; h++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("discarded_hit_level", 32'(level), 32'd4);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_discard_level", 32'(level), 32'd5);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("over_state", 32'(game_state), 32'd4);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_lives", 32'(lives), 32'd0);
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            ticks += int'(beat_tick);
        end
        check("over_no_ticks", ticks, 0);
        check("over_ignores_pause", 32'(game_state), 32'd4);

        // Restart from OVER
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_level", 32'(level), 32'd0);
        next_tick(gap); check("restart_gap1", gap, 9);

        // Pause during countdown returns to countdown
        idle(1, 1'b0);
        check("cd_before_pause", 32'(countdown), 32'd2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("cd_pause_state", 32'(game_state), 32'd3);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            ticks += int'(beat_tick);
        end
        check("cd_pause_no_ticks", ticks, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cd_resume_state", 32'(game_state), 32'd1);
        check("cd_resume_cd", 32'(countdown), 32'd2);
        next_tick(gap);
        next_tick(gap); check("restart_period", gap, 10);
        idle(1, 1'b0);
        check("play_again", 32'(game_state), 32'd2);

        // Pause in PLAY with the counter frozen at 5
        idle(4, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("play_pause_state", 32'(game_state), 32'd3);
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            ticks += int'(beat_tick);
        end
        check("play_pause_no_ticks", ticks, 0);
        check("pause_ignores_loss", 32'(lives), 32'd3);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("play_resume_state", 32'(game_state), 32'd2);
        next_tick(gap); check("resume_tick_gap", gap, 4);

        // Asynchronous reset mid-PLAY at level 2
        for (int h = 0; h < 2 * HITS; h++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_reset_level", 32'(level), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_state", 32'(game_state), 32'd0);
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_lives", 32'(lives), 32'd3);
        check("async_rst_tick", 32'(beat_tick), 32'd0);
        apply_reset();

        // Randomized play against the model
        p = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) p = ~p;
            cycle($urandom_range(0, 19) == 0, p, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
